// File: rtl/barrett_precompute.sv
// Barrett constant generator: for modulus m computes R = 2*bitlen(m) and floor(2^R / m).
// Ports: sys_clk, sys_rst_n, start, modulus in; busy, done, error, R, constant out.
module barrett_precompute #(
    parameter int BITWIDTH = 32
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic [BITWIDTH-1:0] modulus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [BITWIDTH-1:0] R,
    output logic [BITWIDTH+1:0] constant
);

    localparam int KW = $clog2(BITWIDTH + 1);
    localparam int CW = $clog2(2 * BITWIDTH + 2);

    typedef enum logic [1:0] {IDLE, SIZE, DIV, DONE} state_t;

    state_t state_q, state_d;

    logic [BITWIDTH-1:0] m_q, m_d;
    logic [BITWIDTH:0]   rem_q, rem_d;
    logic [BITWIDTH+1:0] quo_q, quo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                first_q, first_d;
    logic                err_q, err_d;
    logic [BITWIDTH-1:0] r_q, r_d;
    logic [BITWIDTH+1:0] const_q, const_d;

    logic [KW-1:0]       k;
    logic [CW-1:0]       two_k;
    logic [BITWIDTH+1:0] rem_sh;
    logic [BITWIDTH+1:0] rem_sub;
    logic                ge;
    logic [BITWIDTH+1:0] quo_sh;

    // Priority encoder: highest set bit wins, k = index + 1.
    always_comb begin
        k = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            if (m_q[i]) k = KW'(i + 1);
        end
        two_k = CW'(k) << 1;
    end

    // One restoring-division step; the dividend is 2^R, so only its
    // leading bit is 1 and every later bit shifted in is 0.
    always_comb begin
        rem_sh  = {rem_q, first_q};
        ge      = rem_sh >= {2'b00, m_q};
        rem_sub = rem_sh - {2'b00, m_q};
        quo_sh  = (BITWIDTH + 2)'({quo_q, ge});
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = SIZE;
            SIZE: state_d = (m_q == '0) ? DONE : DIV;
            DIV:  if (cnt_q == CW'(1)) state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        m_d     = m_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        err_d   = err_q;
        r_d     = r_q;
        const_d = const_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d   = modulus;
                    err_d = 1'b0;
                end
            end
            SIZE: begin
                if (m_q == '0) begin
                    err_d   = 1'b1;
                    r_d     = '0;
                    const_d = '0;
                end else begin
                    r_d     = BITWIDTH'(two_k);
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = two_k + CW'(1);
                    first_d = 1'b1;
                end
            end
            DIV: begin
                rem_d   = (BITWIDTH + 1)'(ge ? rem_sub : rem_sh);
                quo_d   = quo_sh;
                cnt_d   = cnt_q - CW'(1);
                first_d = 1'b0;
                if (cnt_q == CW'(1)) const_d = quo_sh;
            end
            DONE: begin
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            r_q     <= '0;
            const_q <= '0;
        end else begin
            m_q     <= m_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            err_q   <= err_d;
            r_q     <= r_d;
            const_q <= const_d;
        end
    end

    assign error    = err_q;
    assign R        = r_q;
    assign constant = const_q;

endmodule

// File: tb/tb_barrett_precompute.sv
// Directed bench for barrett_precompute with a result scoreboard.
// Expected R/constant/latency come from a native-division reference model.
module tb_barrett_precompute;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] modulus = '0;
    logic        busy, done, error;
    logic [31:0] R;
    logic [33:0] constant;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] m;
        int          r;
        logic [33:0] c;
        bit          e;
        int          lat;
    } exp_t;

    exp_t sb[$];

    barrett_precompute #(.BITWIDTH(32)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .start    (start),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .R        (R),
        .constant (constant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] m);
        exp_t        x;
        int          k;
        logic [127:0] big;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        x.m = m;
        if (m == 0) begin
            x.r = 0; x.c = '0; x.e = 1'b1; x.lat = 1;
        end else begin
            x.r   = 2 * k;
            big   = 128'(1) << x.r;
            x.c   = 34'(big / {96'd0, m});
            x.e   = 1'b0;
            x.lat = 2 * k + 2;
        end
        return x;
    endfunction

    task automatic run(input logic [31:0] m, input bit poke_mid,
                       input bit poke_done);
        int   n;
        bit   got;
        bit   all_busy;
        exp_t x;
        @(negedge clk);
        modulus = m;
        start   = 1'b1;
        sb.push_back(model(m));
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; got = 0; all_busy = 1;
        while (!got && n < 200) begin
            @(posedge clk);
            #1 n++;
            if (done) got = 1;
            else if (!busy) all_busy = 0;
            if (poke_mid && n == 4) begin
                start = 1'b1; modulus = 32'd5;
            end else if (poke_mid && n == 5) begin
                start = 1'b0;
            end
        end
        x = sb.pop_front();
        chk("done_seen", 128'(got), 128'(1));
        chk("latency", 128'(n), 128'(x.lat));
        chk("busy_during", 128'(all_busy), 128'(1));
        chk("R", 128'(R), 128'(x.r));
        chk("constant", 128'(constant), 128'(x.c));
        chk("error", 128'(error), 128'(x.e));
        if (poke_done) begin
            start = 1'b1; modulus = 32'd5;
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", 128'(done), 128'(0));
        chk("idle_after", 128'(busy), 128'(0));
        chk("constant_hold", 128'(constant), 128'(x.c));
        chk("R_hold", 128'(R), 128'(x.r));
        start = 1'b0;
    endtask

    initial begin
        bit saw;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_error", 128'(error), 128'(0));
        chk("rst_R", 128'(R), 128'(0));
        chk("rst_constant", 128'(constant), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run(32'd7, 0, 0);
        run(32'd1, 0, 0);
        run(32'h8000_0000, 0, 0);
        run(32'hFFFF_FFFF, 0, 0);
        run(32'd0, 0, 0);
        run(32'd7, 0, 0);
        run(32'd7, 1, 0);
        run(32'd5, 0, 1);
        run(32'd12345, 0, 0);

        @(negedge clk);
        modulus = 32'd7;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_error", 128'(error), 128'(0));
        chk("abort_R", 128'(R), 128'(0));
        chk("abort_constant", 128'(constant), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        saw = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done || busy) saw = 1;
        end
        chk("no_done_after_abort", 128'(saw), 128'(0));

        run(32'd7, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
